// File: rtl/unidade_controle_if.sv
// Control/datapath/memory handshake bundle between unidade_controle and DataFlow.
// The master side is the control unit. The slave side is the datapath plus the memories.
interface unidade_controle_if;
    // decoded instruction fields and ULA flags coming back from DataFlow
    logic [6:0]  upcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        flag_igual;
    logic        flag_menor;
    logic        flag_maior_igual_u;
    logic        imem_ack;
    logic        dmem_ack;

    logic        imem_req;
    logic        ir_we;
    logic [1:0]  soma_ou_subtrai;
    logic        usa_imm_ula;
    logic [2:0]  select_imm_conv;
    logic        WeR;
    logic [1:0]  dinR_sel;
    logic        dmem_req;
    logic        dmem_we;
    logic        pc_we;
    logic        pc_sel;
    logic        halt;
    logic [31:0] instr_count;

    modport master (
        input  upcode, funct3, funct7,
        input  flag_igual, flag_menor, flag_maior_igual_u,
        input  imem_ack, dmem_ack,
        output imem_req, ir_we, soma_ou_subtrai, usa_imm_ula, select_imm_conv,
        output WeR, dinR_sel, dmem_req, dmem_we, pc_we, pc_sel, halt, instr_count
    );

    modport slave (
        output upcode, funct3, funct7,
        output flag_igual, flag_menor, flag_maior_igual_u,
        output imem_ack, dmem_ack,
        input  imem_req, ir_we, soma_ou_subtrai, usa_imm_ula, select_imm_conv,
        input  WeR, dinR_sel, dmem_req, dmem_we, pc_we, pc_sel, halt, instr_count
    );
endinterface

// File: rtl/unidade_controle.sv
// Multi-cycle control FSM for the RV64 DataFlow datapath (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Outputs are decoded combinationally from the state and the IR fields held in DataFlow.
module unidade_controle (
    input  logic clk,
    input  logic rst_n,
    unidade_controle_if.master bus
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_J = 3'd1;
    localparam logic [2:0] IMM_U = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_S = 3'd4;

    localparam logic [1:0] ULA_SOMA    = 2'd1;
    localparam logic [1:0] ULA_SUBTRAI = 2'd2;

    localparam logic [1:0] WB_ULA = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    logic [2:0]  state_q, state_d;
    logic [31:0] instr_count_q;

    logic is_add, is_sub, is_addi, is_ld, is_sd, is_br, is_jal, is_lui, legal;
    logic br_taken;
    logic [1:0] ula_op;
    logic       ula_imm;
    logic [2:0] imm_sel;

    // instruction classification from the IR fields
    always_comb begin
        is_add  = (bus.upcode == OP_R) && (bus.funct3 == 3'b000) && (bus.funct7 == 7'b0000000);
        is_sub  = (bus.upcode == OP_R) && (bus.funct3 == 3'b000) && (bus.funct7 == 7'b0100000);
        is_addi = (bus.upcode == OP_I) && (bus.funct3 == 3'b000);
        is_ld   = (bus.upcode == OP_LD) && (bus.funct3 == 3'b011);
        is_sd   = (bus.upcode == OP_SD) && (bus.funct3 == 3'b011);
        is_br   = (bus.upcode == OP_BR) &&
                  ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b111));
        is_jal  = (bus.upcode == OP_JAL);
        is_lui  = (bus.upcode == OP_LUI);
        legal   = is_add | is_sub | is_addi | is_ld | is_sd | is_br | is_jal | is_lui;
    end

    always_comb begin
        br_taken = 1'b0;
        case (bus.funct3)
            3'b000:  br_taken = bus.flag_igual;
            3'b100:  br_taken = bus.flag_menor;
            3'b111:  br_taken = bus.flag_maior_igual_u;
            default: br_taken = 1'b0;
        endcase
    end

    // ULA setup chosen in EXEC and held through MEM/WB so DataFlow keeps routing rd/rs1/rs2
    always_comb begin
        ula_op  = (is_sub || is_br) ? ULA_SUBTRAI : ULA_SOMA;
        ula_imm = is_addi | is_ld | is_sd | is_lui | is_jal;
        if (is_sd)
            imm_sel = IMM_S;
        else if (is_lui)
            imm_sel = IMM_U;
        else if (is_jal)
            imm_sel = IMM_J;
        else if (is_br)
            imm_sel = IMM_B;
        else
            imm_sel = IMM_I;
    end

    always_comb begin
        state_d             = state_q;
        bus.imem_req        = 1'b0;
        bus.ir_we           = 1'b0;
        bus.soma_ou_subtrai = 2'd0;
        bus.usa_imm_ula     = 1'b0;
        bus.select_imm_conv = 3'd0;
        bus.WeR             = 1'b0;
        bus.dinR_sel        = 2'd0;
        bus.dmem_req        = 1'b0;
        bus.dmem_we         = 1'b0;
        bus.pc_we           = 1'b0;
        bus.pc_sel          = 1'b0;
        bus.halt            = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.imem_req = 1'b1;
                bus.ir_we    = bus.imem_ack;
                if (bus.imem_ack)
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                bus.soma_ou_subtrai = ula_op;
                bus.usa_imm_ula     = ula_imm;
                bus.select_imm_conv = imm_sel;
                if (is_br) begin
                    bus.pc_we  = 1'b1;
                    bus.pc_sel = br_taken;
                    state_d    = S_FETCH;
                end else if (is_ld || is_sd) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                bus.soma_ou_subtrai = ula_op;
                bus.usa_imm_ula     = ula_imm;
                bus.select_imm_conv = imm_sel;
                bus.dmem_req        = 1'b1;
                bus.dmem_we         = is_sd;
                if (bus.dmem_ack) begin
                    if (is_sd) begin
                        // stores retire here; no writeback cycle
                        bus.pc_we = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                bus.soma_ou_subtrai = ula_op;
                bus.usa_imm_ula     = ula_imm;
                bus.select_imm_conv = imm_sel;
                bus.WeR             = 1'b1;
                bus.pc_we           = 1'b1;
                bus.pc_sel          = is_jal;
                if (is_ld)
                    bus.dinR_sel = WB_MEM;
                else if (is_jal)
                    bus.dinR_sel = WB_PC4;
                else if (is_lui)
                    bus.dinR_sel = WB_IMM;
                else
                    bus.dinR_sel = WB_ULA;
                state_d = S_FETCH;
            end
            S_HALT: begin
                bus.halt = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    // one retirement per PC update; wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instr_count_q <= 32'd0;
        else if (bus.pc_we)
            instr_count_q <= instr_count_q + 32'd1;
    end

    assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed, table-driven bench for unidade_controle: per-cycle output vectors plus
// hand-written sequences for stalled memory, illegal-instruction halt, async reset and counter wrap.
module tb_unidade_controle;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    unidade_controle_if bus();

    unidade_controle dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [2:0]  fl;   // {igual, menor, maior_igual_u}
        logic        iack;
        logic        dack;
        logic [15:0] ectl;
        logic [31:0] ecnt;
    } vec_t;

    vec_t tbl[$];

    // {imem_req, ir_we, soma_ou_subtrai, usa_imm, sel, WeR, dinR_sel, dmem_req, dmem_we, pc_we, pc_sel, halt}
    function automatic logic [15:0] ctl(input logic ireq, input logic irwe, input logic [1:0] sos,
                                        input logic usa, input logic [2:0] sel, input logic wer,
                                        input logic [1:0] ds, input logic dreq, input logic dwe,
                                        input logic pcwe, input logic pcsel, input logic hlt);
        return {ireq, irwe, sos, usa, sel, wer, ds, dreq, dwe, pcwe, pcsel, hlt};
    endfunction

    function automatic logic [15:0] dut_ctl();
        return {bus.imem_req, bus.ir_we, bus.soma_ou_subtrai, bus.usa_imm_ula, bus.select_imm_conv,
                bus.WeR, bus.dinR_sel, bus.dmem_req, bus.dmem_we, bus.pc_we, bus.pc_sel, bus.halt};
    endfunction

    task automatic addv(input string nm, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [2:0] fl, input logic iack, input logic dack,
                        input logic [15:0] ectl, input logic [31:0] ecnt);
        vec_t v;
        v.nm = nm; v.op = op; v.f3 = f3; v.f7 = f7; v.fl = fl;
        v.iack = iack; v.dack = dack; v.ectl = ectl; v.ecnt = ecnt;
        tbl.push_back(v);
    endtask

    task automatic chk_ctl(input string nm, input logic [15:0] exp_ctl);
        n_chk++;
        if (dut_ctl() !== exp_ctl) begin
            n_fail++;
            $display("FAIL %s: ctl got %h want %h", nm, dut_ctl(), exp_ctl);
        end
    endtask

    task automatic chk_cnt(input string nm, input logic [31:0] exp_cnt);
        n_chk++;
        if (bus.instr_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s: instr_count got %h want %h", nm, bus.instr_count, exp_cnt);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [2:0] fl, input logic iack, input logic dack);
        bus.upcode             = op;
        bus.funct3             = f3;
        bus.funct7             = f7;
        bus.flag_igual         = fl[2];
        bus.flag_menor         = fl[1];
        bus.flag_maior_igual_u = fl[0];
        bus.imem_ack           = iack;
        bus.dmem_ack           = dack;
    endtask

    // one clock: drive on the falling edge, compare 1 ns later, state advances on the next rise
    task automatic step(input string nm, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [2:0] fl, input logic iack, input logic dack,
                        input logic [15:0] ectl, input logic do_cnt, input logic [31:0] ecnt);
        @(negedge clk);
        drive(op, f3, f7, fl, iack, dack);
        #1;
        chk_ctl(nm, ectl);
        if (do_cnt)
            chk_cnt(nm, ecnt);
    endtask

    task automatic halt_hold(input string nm);
        int bad;
        logic [15:0] first_bad;
        bad = 0;
        first_bad = 16'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.imem_ack = 1'b1;
            bus.dmem_ack = i[0];
            #1;
            if (dut_ctl() !== ctl(0,0,0,0,0,0,0,0,0,0,0,1)) begin
                if (bad == 0)
                    first_bad = dut_ctl();
                bad++;
            end
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s: %0d bad cycles, first ctl %h want %h", nm, bad, first_bad,
                     ctl(0,0,0,0,0,0,0,0,0,0,0,1));
        end
    endtask

    task automatic reset_to_fetch(input string nm);
        @(negedge clk);
        bus.imem_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_ctl(nm, ctl(1,1,0,0,0,0,0,0,0,0,0,0));
        chk_cnt(nm, 32'd0);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        rst_n = 1'b1;
    endtask

    logic [15:0] CF, CFW, C0;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        CF  = ctl(1,1,0,0,0,0,0,0,0,0,0,0);
        CFW = ctl(1,0,0,0,0,0,0,0,0,0,0,0);
        C0  = 16'h0000;

        // add / sub
        addv("add.F", OP_R, 0, 0, 0, 1, 0, CF, 0);
        addv("add.D", OP_R, 0, 0, 0, 1, 0, C0, 0);
        addv("add.E", OP_R, 0, 0, 0, 0, 0, ctl(0,0,1,0,0,0,0,0,0,0,0,0), 0);
        addv("add.W", OP_R, 0, 0, 0, 0, 0, ctl(0,0,1,0,0,1,0,0,0,1,0,0), 0);
        addv("sub.F", OP_R, 0, 7'h20, 0, 1, 0, CF, 1);
        addv("sub.D", OP_R, 0, 7'h20, 0, 0, 0, C0, 1);
        addv("sub.E", OP_R, 0, 7'h20, 0, 0, 0, ctl(0,0,2,0,0,0,0,0,0,0,0,0), 1);
        addv("sub.W", OP_R, 0, 7'h20, 0, 0, 0, ctl(0,0,2,0,0,1,0,0,0,1,0,0), 1);
        // branches: condition must come from the flag selected by funct3
        addv("beqT.F", OP_BR, 0, 0, 3'b100, 1, 0, CF, 2);
        addv("beqT.D", OP_BR, 0, 0, 3'b100, 0, 0, C0, 2);
        addv("beqT.E", OP_BR, 0, 0, 3'b100, 0, 0, ctl(0,0,2,0,3,0,0,0,0,1,1,0), 2);
        addv("beqN.F", OP_BR, 0, 0, 3'b011, 1, 0, CF, 3);
        addv("beqN.D", OP_BR, 0, 0, 3'b011, 0, 0, C0, 3);
        addv("beqN.E", OP_BR, 0, 0, 3'b011, 0, 0, ctl(0,0,2,0,3,0,0,0,0,1,0,0), 3);
        addv("bgeu.F", OP_BR, 7, 0, 3'b001, 1, 0, CF, 4);
        addv("bgeu.D", OP_BR, 7, 0, 3'b001, 0, 0, C0, 4);
        addv("bgeu.E", OP_BR, 7, 0, 3'b001, 0, 0, ctl(0,0,2,0,3,0,0,0,0,1,1,0), 4);
        addv("bltN.F", OP_BR, 4, 0, 3'b101, 1, 0, CF, 5);
        addv("bltN.D", OP_BR, 4, 0, 3'b101, 0, 0, C0, 5);
        addv("bltN.E", OP_BR, 4, 0, 3'b101, 0, 0, ctl(0,0,2,0,3,0,0,0,0,1,0,0), 5);
        // addi with one fetch wait state
        addv("addi.Fw", OP_I, 0, 0, 0, 0, 0, CFW, 6);
        addv("addi.F", OP_I, 0, 0, 0, 1, 0, CF, 6);
        addv("addi.D", OP_I, 0, 0, 0, 0, 0, C0, 6);
        addv("addi.E", OP_I, 0, 0, 0, 0, 0, ctl(0,0,1,1,0,0,0,0,0,0,0,0), 6);
        addv("addi.W", OP_I, 0, 0, 0, 0, 0, ctl(0,0,1,1,0,1,0,0,0,1,0,0), 6);
        addv("lui.F", OP_LUI, 0, 0, 0, 1, 0, CF, 7);
        addv("lui.D", OP_LUI, 0, 0, 0, 0, 0, C0, 7);
        addv("lui.E", OP_LUI, 0, 0, 0, 0, 0, ctl(0,0,1,1,2,0,0,0,0,0,0,0), 7);
        addv("lui.W", OP_LUI, 0, 0, 0, 0, 0, ctl(0,0,1,1,2,1,3,0,0,1,0,0), 7);
        addv("jal.F", OP_JAL, 0, 0, 0, 1, 0, CF, 8);
        addv("jal.D", OP_JAL, 0, 0, 0, 0, 0, C0, 8);
        addv("jal.E", OP_JAL, 0, 0, 0, 0, 0, ctl(0,0,1,1,1,0,0,0,0,0,0,0), 8);
        addv("jal.W", OP_JAL, 0, 0, 0, 0, 0, ctl(0,0,1,1,1,1,2,0,0,1,1,0), 8);
        // sd: dmem_ack during EXEC is ignored, one MEM wait state
        addv("sd.F", OP_SD, 3, 0, 0, 1, 0, CF, 9);
        addv("sd.D", OP_SD, 3, 0, 0, 0, 0, C0, 9);
        addv("sd.E", OP_SD, 3, 0, 0, 0, 1, ctl(0,0,1,1,4,0,0,0,0,0,0,0), 9);
        addv("sd.Mw", OP_SD, 3, 0, 0, 0, 0, ctl(0,0,1,1,4,0,0,1,1,0,0,0), 9);
        addv("sd.M", OP_SD, 3, 0, 0, 0, 1, ctl(0,0,1,1,4,0,0,1,1,1,0,0), 9);
        addv("ld.F", OP_LD, 3, 0, 0, 1, 0, CF, 10);
        addv("ld.D", OP_LD, 3, 0, 0, 0, 0, C0, 10);
        addv("ld.E", OP_LD, 3, 0, 0, 0, 0, ctl(0,0,1,1,0,0,0,0,0,0,0,0), 10);
        addv("ld.M", OP_LD, 3, 0, 0, 0, 1, ctl(0,0,1,1,0,0,0,1,0,0,0,0), 10);
        addv("ld.W", OP_LD, 3, 0, 0, 0, 0, ctl(0,0,1,1,0,1,1,0,0,1,0,0), 10);
        addv("end.F", OP_LD, 3, 0, 0, 0, 0, CFW, 11);

        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_ctl("reset", CFW);
        chk_cnt("reset", 32'd0);
        rst_n = 1'b1;

        foreach (tbl[i])
            step(tbl[i].nm, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].fl,
                 tbl[i].iack, tbl[i].dack, tbl[i].ectl, 1'b1, tbl[i].ecnt);

        // ld with dmem_ack three cycles late: 8 cycles FETCH to FETCH
        step("ld3.F", OP_LD, 3, 0, 0, 1, 0, CF, 1'b1, 11);
        step("ld3.D", OP_LD, 3, 0, 0, 0, 0, C0, 1'b0, 0);
        step("ld3.E", OP_LD, 3, 0, 0, 0, 0, ctl(0,0,1,1,0,0,0,0,0,0,0,0), 1'b0, 0);
        for (int i = 0; i < 3; i++)
            step("ld3.Mw", OP_LD, 3, 0, 0, 0, 0, ctl(0,0,1,1,0,0,0,1,0,0,0,0), 1'b0, 0);
        step("ld3.M", OP_LD, 3, 0, 0, 0, 1, ctl(0,0,1,1,0,0,0,1,0,0,0,0), 1'b0, 0);
        step("ld3.W", OP_LD, 3, 0, 0, 0, 0, ctl(0,0,1,1,0,1,1,0,0,1,0,0), 1'b0, 0);
        step("ld3.next", OP_LD, 3, 0, 0, 0, 0, CFW, 1'b1, 12);

        // illegal upcode traps until reset
        step("ill.F", OP_BAD, 0, 0, 0, 1, 0, CF, 1'b1, 12);
        step("ill.D", OP_BAD, 0, 0, 0, 0, 0, C0, 1'b0, 0);
        halt_hold("ill.halt");
        reset_to_fetch("ill.rst");

        // unsupported funct7 on an R-type also traps
        step("r7.F", OP_R, 0, 7'h01, 0, 1, 0, CF, 1'b1, 0);
        step("r7.D", OP_R, 0, 7'h01, 0, 0, 0, C0, 1'b0, 0);
        halt_hold("r7.halt");
        reset_to_fetch("r7.rst");

        // run a few retirements, then reset asynchronously in the middle of a store handshake
        step("pre.F", OP_JAL, 0, 0, 0, 1, 0, CF, 1'b1, 0);
        step("pre.D", OP_JAL, 0, 0, 0, 0, 0, C0, 1'b0, 0);
        step("pre.E", OP_JAL, 0, 0, 0, 0, 0, ctl(0,0,1,1,1,0,0,0,0,0,0,0), 1'b0, 0);
        step("pre.W", OP_JAL, 0, 0, 0, 0, 0, ctl(0,0,1,1,1,1,2,0,0,1,1,0), 1'b0, 0);
        step("rm.F", OP_SD, 3, 0, 0, 1, 0, CF, 1'b1, 1);
        step("rm.D", OP_SD, 3, 0, 0, 0, 0, C0, 1'b0, 0);
        step("rm.E", OP_SD, 3, 0, 0, 0, 0, ctl(0,0,1,1,4,0,0,0,0,0,0,0), 1'b0, 0);
        step("rm.M", OP_SD, 3, 0, 0, 0, 0, ctl(0,0,1,1,4,0,0,1,1,0,0,0), 1'b0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_ctl("rm.rst", CFW);
        chk_cnt("rm.rst", 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("rm.after", OP_SD, 3, 0, 0, 0, 0, CFW, 1'b1, 0);

        // counter wrap: preload all-ones, retire one branch
        #1;
        force dut.instr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count_q;
        #1;
        chk_cnt("wrap.pre", 32'hFFFF_FFFF);
        step("wrap.F", OP_BR, 0, 0, 3'b100, 1, 0, CF, 1'b1, 32'hFFFF_FFFF);
        step("wrap.D", OP_BR, 0, 0, 3'b100, 0, 0, C0, 1'b0, 0);
        step("wrap.E", OP_BR, 0, 0, 3'b100, 0, 0, ctl(0,0,2,0,3,0,0,0,0,1,1,0), 1'b0, 0);
        step("wrap.next", OP_BR, 0, 0, 0, 0, 0, CFW, 1'b1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
